// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- sequencing FSM for the UART receive path.
//
// Walks a frame through START / DATA / PARITY / STOP. While in those states it
// enables the external edge/bit counter and the sampler, and it reads their
// results back. Data is deserialised LSB-first. The block checks for a
// start-bit glitch, a parity error and a stop error. A good frame is
// delivered on p_data together with a one-cycle data_valid strobe.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   rx_in            synchronised serial line (idle high)
//   par_en, par_typ  parity enable / type (0 even, 1 odd); latched at frame start
//   prescale         oversampling ratio (8/16/32, anything else acts as 8)
//   edge_cnt,bit_cnt counter block state (edge within bit, data-bit index)
//   sampled_bit      majority-vote sample of the current bit
//   edge_cnt_en      counter enable (START/DATA/PARITY/STOP)
//   bit_cnt_en       data-bit counter enable (DATA)
//   data_samp_en     sampler enable (same as edge_cnt_en)
//   busy             FSM not idle
//   p_data           last good received word
//   data_valid       one-cycle strobe, high during DONE for a good frame
//   par_err, stp_err error flags, held until the next frame starts
//   strt_glitch      one-cycle strobe when the start bit samples high
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [BIT_CNT_W-1:0]  bit_cnt,
  input  logic                  sampled_bit,
  output logic                  edge_cnt_en,
  output logic                  bit_cnt_en,
  output logic                  data_samp_en,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  cfg_par_en_q, cfg_par_en_d;
  logic                  cfg_par_typ_q, cfg_par_typ_d;
  logic [PRESCALE_W-1:0] cfg_p_q, cfg_p_d;

  logic [PRESCALE_W-1:0] p_eff;
  logic                  check_edge, bit_end, last_bit, par_exp, enter_start;

  // Unsupported ratios fall back to 8 so the frame timing stays well defined.
  always_comb begin
    p_eff = PRESCALE_W'(8);
    if (prescale == PRESCALE_W'(8) || prescale == PRESCALE_W'(16) ||
        prescale == PRESCALE_W'(32))
      p_eff = prescale;
  end

  // Sampler result is ready two edges after mid-bit.
  assign check_edge = (edge_cnt == (cfg_p_q >> 1) + PRESCALE_W'(2));
  assign bit_end    = (edge_cnt == cfg_p_q - PRESCALE_W'(1));
  assign last_bit   = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign par_exp    = (^shift_q) ^ cfg_par_typ_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    strt_glitch_d = 1'b0;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_typ_d = cfg_par_typ_q;
    cfg_p_d       = cfg_p_q;
    enter_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_in) enter_start = 1'b1;
      end
      S_START: begin
        if (check_edge && sampled_bit) begin
          strt_glitch_d = 1'b1;
          state_d       = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Line is LSB-first: each new bit enters at the MSB and moves down.
        if (check_edge) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        if (bit_end && last_bit) state_d = cfg_par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (check_edge && (sampled_bit != par_exp)) par_err_d = 1'b1;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Decide at the sample point; the tail of the stop bit is not waited
        // for so a following start bit can be caught from DONE.
        if (check_edge) begin
          state_d = S_DONE;
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
          end else if (!par_err_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      S_DONE: begin
        if (!rx_in) enter_start = 1'b1;
        else        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_start) begin
      state_d       = S_START;
      par_err_d     = 1'b0;
      stp_err_d     = 1'b0;
      cfg_par_en_d  = par_en;
      cfg_par_typ_d = par_typ;
      cfg_p_d       = p_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_typ_q <= 1'b0;
      cfg_p_q       <= PRESCALE_W'(8);
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_typ_q <= cfg_par_typ_d;
      cfg_p_q       <= cfg_p_d;
    end
  end

  // DONE keeps the enables low so the counter block clears between frames.
  assign edge_cnt_en  = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
  assign bit_cnt_en   = (state_q == S_DATA);
  assign data_samp_en = edge_cnt_en;
  assign busy         = (state_q != S_IDLE);
  assign p_data       = p_data_q;
  assign data_valid   = data_valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;
  assign strt_glitch  = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. A small behavioural counter block drives
// edge_cnt/bit_cnt from the DUT enables; the bench drives sampled_bit with
// the ideal value of the bit being received.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit = 1'b1;
  logic       edge_cnt_en, bit_cnt_en, data_samp_en, busy;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, strt_glitch;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, cnt_p = 8;
  int dv_cnt = 0, dv_cyc = 0;
  logic [7:0] dv_data = 8'h00;
  logic [5:0] pre_mid = 6'd0;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sampled_bit(sampled_bit), .edge_cnt_en(edge_cnt_en),
    .bit_cnt_en(bit_cnt_en), .data_samp_en(data_samp_en), .busy(busy),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .strt_glitch(strt_glitch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter block model: clears while disabled, wraps at cnt_p-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= 6'd0; bit_cnt <= 4'd0;
    end else if (!edge_cnt_en) begin
      edge_cnt <= 6'd0; bit_cnt <= 4'd0;
    end else if (int'(edge_cnt) == cnt_p - 1) begin
      edge_cnt <= 6'd0;
      if (bit_cnt_en) bit_cnt <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  = dv_cnt + 1;
      dv_cyc  = cyc;
      dv_data = p_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Drive one frame. entered=1 means the DUT already sits in START (came from
  // DONE). b2b=1 holds rx_in low through DONE to start the next frame.
  task automatic send_frame(input int p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic stop_v,
                            input logic b2b, input logic entered);
    cnt_p = p;
    if (!entered) begin rx_in = 1'b0; sampled_bit = 1'b0; tick(); end
    start_cyc = cyc;
    for (int c = 0; c < p; c++) begin rx_in = 1'b0; sampled_bit = 1'b0; tick(); end
    for (int i = 0; i < 8; i++) begin
      if (i == 4 && pre_mid != 6'd0) prescale = pre_mid;
      for (int c = 0; c < p; c++) begin rx_in = d[i]; sampled_bit = d[i]; tick(); end
    end
    if (pen)
      for (int c = 0; c < p; c++) begin rx_in = pbit; sampled_bit = pbit; tick(); end
    for (int c = 0; c <= p/2 + 2; c++) begin rx_in = stop_v; sampled_bit = stop_v; tick(); end
    rx_in = b2b ? 1'b0 : 1'b1; sampled_bit = 1'b1; tick();
  endtask

  initial begin
    int base;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_pdata", p_data, 8'h00);
    chk("rst_dv", data_valid, 0);
    chk("rst_errs", {par_err, stp_err, strt_glitch}, 3'b000);
    chk("rst_en", {edge_cnt_en, bit_cnt_en, data_samp_en}, 3'b000);
    @(negedge clk); rst = 1'b1;
    repeat (3) tick();

    // Good frame, P=8, even parity, 0xA5
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    base = dv_cnt;
    send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("a5_dv_cnt", dv_cnt - base, 1);
    chk("a5_latency", dv_cyc - start_cyc, 87);
    chk("a5_dv_data", dv_data, 8'hA5);
    chk("a5_pdata", p_data, 8'hA5);
    chk("a5_errs", {par_err, stp_err}, 2'b00);
    chk("a5_idle", busy, 0);

    // Same frame with wrong parity bit
    base = dv_cnt;
    send_frame(8, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    chk("perr_flag", par_err, 1);
    chk("perr_stp", stp_err, 0);
    chk("perr_no_dv", dv_cnt - base, 0);
    chk("perr_pdata", p_data, 8'hA5);

    // P=16, no parity, stop error on 0x3C
    prescale = 6'd16; par_en = 1'b0;
    base = dv_cnt;
    send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("serr_flag", stp_err, 1);
    chk("serr_par_cleared", par_err, 0);
    chk("serr_no_dv", dv_cnt - base, 0);
    chk("serr_pdata", p_data, 8'hA5);
    // Next good frame clears stp_err at START
    rx_in = 1'b0; sampled_bit = 1'b0; tick();
    chk("start_clr_stp", stp_err, 0);
    chk("start_busy", {busy, edge_cnt_en, bit_cnt_en}, 3'b110);
    base = dv_cnt;
    send_frame(16, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("x81_dv_cnt", dv_cnt - base, 1);
    chk("x81_latency", dv_cyc - start_cyc, 155);
    chk("x81_pdata", p_data, 8'h81);
    chk("x81_errs", {par_err, stp_err}, 2'b00);

    // Start glitch at P=8: rx_in low 3 cycles, sampled high at edge 6
    prescale = 6'd8; cnt_p = 8;
    base = dv_cnt;
    rx_in = 1'b0; sampled_bit = 1'b0; tick();
    for (int c = 0; c <= 6; c++) begin
      rx_in = (c < 2) ? 1'b0 : 1'b1; sampled_bit = (c < 2) ? 1'b0 : 1'b1; tick();
    end
    chk("glitch_pulse", strt_glitch, 1);
    chk("glitch_idle", busy, 0);
    tick();
    chk("glitch_one_cycle", strt_glitch, 0);
    // Glitch with rx_in still low re-enters START
    rx_in = 1'b0; sampled_bit = 1'b0; tick();
    for (int c = 0; c <= 6; c++) begin rx_in = 1'b1; sampled_bit = 1'b1; tick(); end
    rx_in = 1'b0;
    chk("glitch2_pulse", {strt_glitch, busy}, 2'b10);
    tick();
    chk("glitch2_reenter", {strt_glitch, busy}, 2'b01);
    for (int c = 0; c <= 6; c++) begin rx_in = 1'b1; sampled_bit = 1'b1; tick(); end
    tick();
    chk("glitch_no_dv", dv_cnt - base, 0);
    chk("glitch_pdata", p_data, 8'h81);

    // Back-to-back frames, P=8, no parity
    par_en = 1'b0;
    base = dv_cnt;
    send_frame(8, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b2b1_dv", dv_cnt - base, 1);
    chk("b2b1_data", dv_data, 8'h11);
    chk("b2b_in_start", busy, 1);
    send_frame(8, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b2_dv", dv_cnt - base, 2);
    chk("b2b2_data", dv_data, 8'hEE);
    chk("b2b2_latency", dv_cyc - start_cyc, 79);

    // prescale=12 acts as 8; change to 32 mid-frame is ignored
    prescale = 6'd12; par_en = 1'b1; par_typ = 1'b0; pre_mid = 6'd32;
    base = dv_cnt;
    send_frame(8, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pre_mid = 6'd0;
    chk("p12_dv", dv_cnt - base, 1);
    chk("p12_latency", dv_cyc - start_cyc, 87);
    chk("p12_pdata", p_data, 8'h5A);

    // Reset in the middle of DATA
    prescale = 6'd8; par_en = 1'b0; cnt_p = 8;
    base = dv_cnt;
    rx_in = 1'b0; sampled_bit = 1'b0; tick();
    for (int c = 0; c < 20; c++) begin rx_in = c[0]; sampled_bit = c[0]; tick(); end
    chk("mid_data_en", {busy, edge_cnt_en, bit_cnt_en, data_samp_en}, 4'b1111);
    rst = 1'b0; #2;
    chk("mid_rst_busy", {busy, edge_cnt_en, bit_cnt_en}, 3'b000);
    chk("mid_rst_pdata", p_data, 8'h00);
    chk("mid_rst_flags", {data_valid, par_err, stp_err, strt_glitch}, 4'b0000);
    rx_in = 1'b1; sampled_bit = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (100) tick();
    chk("mid_rst_no_dv", dv_cnt - base, 0);
    chk("mid_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing FSM for the UART receive path. It drives the oversampling edge/bit counter enables and consumes the counter values and the majority-sampled bit.
- It also performs start-glitch, parity and stop checks, and deserialises data LSB-first into a parallel word with a one-cycle valid strobe.
- It sits between the synchronised rx line, the edge/bit counter block and the RX output interface.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the prescale and edge_cnt buses.
- BIT_CNT_W, 4, width of the bit_cnt bus.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- rx_in  input  1  serial line, already synchronised to clk; idle high
- par_en  input  1  1 = frame carries a parity bit
- par_typ  input  1  0 = even, 1 = odd
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- edge_cnt  input  PRESCALE_W  counter block edge count within the current bit; 0 at the first enabled cycle
- bit_cnt  input  BIT_CNT_W  counter block data-bit index; advances only while bit_cnt_en is high
- sampled_bit  input  1  majority-vote sample from the sampler
- edge_cnt_en  output  1  combinational; high in START/DATA/PARITY/STOP
- bit_cnt_en  output  1  combinational; high in DATA only
- data_samp_en  output  1  combinational; equal to edge_cnt_en
- busy  output  1  combinational; state != IDLE
- p_data  output  DATA_WIDTH  last good received word
- data_valid  output  1  one-cycle strobe
- par_err  output  1  parity error of the current/last frame
- stp_err  output  1  stop error of the current/last frame
- strt_glitch  output  1  one-cycle strobe

Behaviour:
- Reset (async, rst=0): state=IDLE; shift register, p_data, data_valid, par_err, stp_err, strt_glitch all 0; latched configuration = {par_en 0, par_typ 0, P 8}. Release is synchronous to the next clk edge.
- Config latch: on the IDLE->START (or DONE->START) transition, latch par_en, par_typ and the effective prescale P. P = prescale if it is 8/16/32, otherwise 8. Changes mid-frame are ignored.
- Derived edges:
  - check_edge: edge_cnt == P/2+2.
  - bit_end: edge_cnt == P-1.
- IDLE: on rx_in==0, go to START next cycle.
- START:
  - On entry clear par_err and stp_err.
  - At check_edge with sampled_bit==1: pulse strt_glitch for 1 cycle and go to IDLE.
  - At bit_end: go to DATA.
- DATA:
  - At check_edge: shift sampled_bit in at the MSB, shifting right (LSB-first line order).
  - At bit_end with bit_cnt == DATA_WIDTH-1: go to PARITY if latched par_en, else STOP.
- PARITY:
  - At check_edge: expected = XOR of shift register (even), or its inverse (odd).
  - sampled_bit != expected sets par_err.
  - At bit_end: go to STOP.
- STOP:
  - At check_edge: sampled_bit==0 sets stp_err, and the FSM goes to DONE next cycle.
  - The remaining stop-bit edges are not waited for.
- DONE (1 cycle, counter enables low so the counter clears):
  - If neither error: data_valid=1 and p_data loaded from the shift register, both registered so they are visible during DONE.
  - Next state: START if rx_in==0, else IDLE.
- Latency: data_valid high exactly 1 cycle, (1+DATA_WIDTH+par_en)*P + P/2+2 + 1 cycles after the first START cycle.
- Errors: par_err and stp_err are held until the next START entry. A frame with any error never asserts data_valid, and p_data keeps its previous value.
- Simultaneous events: a PARITY check that sets par_err followed by a stop error keeps both flags set. A strt_glitch return to IDLE with rx_in still 0 re-enters START on the next cycle.
- Reset mid-frame: immediate IDLE, no data_valid, partial word discarded.

Test Plan:
- P=8, par_en=1 even, frame 0xA5 (parity 0, stop 1) -> data_valid 1 cycle at 87 cycles after START entry; p_data=0xA5; par_err=0; stp_err=0.
- Same frame, parity bit driven 1 -> par_err=1 held; no data_valid; p_data unchanged.
- P=16, par_en=0, 0x3C with stop bit 0 -> stp_err=1; no data_valid. Next good frame 0x81 clears stp_err at START and delivers 0x81.
- rx_in low for 3 cycles, sampled_bit=1 at edge 6 (P=8) -> strt_glitch 1-cycle pulse, return to IDLE, no data_valid.
- Two back-to-back frames 0x11, 0xEE with rx_in low in the DONE cycle -> DONE->START directly, two data_valid pulses, p_data 0x11 then 0xEE.
- prescale=12 -> behaves as P=8. prescale changed to 32 mid-frame -> ignored. rst pulsed low in DATA -> outputs 0, IDLE, no strobe.
